seq_chunk_adder: RTL
====================

// Module: seq_chunk_adder
// PURPOSE
//  Multi-cycle parametrised add/sub unit. Adds WIDTH-bit operands CHUNK bits per clock.
//  Carry is rippled between chunks through a carry register.
//  Exports a per-chunk carry vector, generalising the per-bit cout of the 3-bit adder.
//  Sits between the operand source and the ALU result mux, with valid/ready on both sides.
// PARAMETERS
//  WIDTH   32  operand/result width; WIDTH % CHUNK == 0 (elaboration $error otherwise)
//  CHUNK   4   bits added per cycle; NCHUNK = WIDTH/CHUNK cycles per operation
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       operand set valid
//  in_ready   out  1       unit can accept operands this cycle
//  a          in   WIDTH   operand A
//  b          in   WIDTH   operand B
//  cin        in   1       carry-in (add mode only)
//  sub        in   1       1: a - b; 0: a + b + cin
//  out_valid  out  1       result valid, held until taken
//  out_ready  in   1       consumer takes result
//  sum        out  WIDTH   result
//  cout       out  NCHUNK  cout[i] = carry out of chunk i; cout[NCHUNK-1] = final carry
//  ovf        out  1       signed overflow (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async on rst_n low): state=IDLE; sum=0, cout=0, ovf=0, out_valid=0.
//    Chunk index and carry register = 0. in_ready=1 after release.
//  - FSM IDLE -> RUN -> DONE.
//    in_ready = (state==IDLE) | (state==DONE & out_ready).
//  - Accept on in_valid & in_ready: latch a, b' = sub ? ~b : b, c0 = sub ? 1 : cin.
//    Clear chunk index, go to RUN. Inputs are ignored when not accepted.
//  - RUN, cycle k (k=0..NCHUNK-1):
//    {c, sum[k*CHUNK +: CHUNK]} = a_chunk + b'_chunk + carry_reg.
//    carry_reg <= c; cout[k] <= c. On k==NCHUNK-1 go to DONE.
//  - DONE: out_valid=1; sum/cout/ovf stable and held while out_ready=0.
//    - out_ready & !in_valid -> IDLE, out_valid drops next cycle.
//    - out_ready & in_valid -> accept new operands, go straight to RUN (back-to-back).
//  - Latency: accept at edge t -> out_valid high after edge t+NCHUNK.
//    Throughput is one op per NCHUNK+1 cycles with out_ready tied high.
//  - sum is modulo 2^WIDTH. Bits not yet computed in RUN hold their previous value.
//    The bench only checks sum when out_valid=1.
//  - Reset mid-RUN or mid-DONE aborts the operation immediately with no output.
//  - CHUNK==WIDTH is legal: NCHUNK=1, single-cycle RUN.
// CONFIGURATION
//  - SEQ_ADDER_OVF_EN defined: ovf computed at the last chunk.
//    ovf = (a[W-1]==b'[W-1]) & (sum[W-1]!=a[W-1]); registered with sum.
//  - Undefined: ovf tied 0, no overflow logic synthesised, port still present.
// TESTING  (T1-T4: WIDTH=8, CHUNK=4; T5: WIDTH=32, CHUNK=4)
//  T1 add: a=8'h3C, b=8'h0F, cin=1, sub=0.
//     -> out_valid 2 cycles after accept; sum=8'h4C, cout=2'b01.
//  T2 sub: a=8'h05, b=8'h07, sub=1.
//     -> sum=8'hFE, cout[1]=0 (borrow); ovf=0.
//  T3 overflow (macro on): a=8'h7F, b=8'h01, cin=0.
//     -> sum=8'h80, ovf=1. Same stimulus with macro off -> ovf=0.
//  T4 backpressure/back-to-back: out_ready=0 for 5 cycles.
//     -> out_valid and sum held, in_ready=0.
//     Then out_ready=1 with in_valid=1 (a=1, b=1) -> next accepted that cycle, sum=8'h02.
//  T5 wrap: a=32'hFFFFFFFF, b=0, cin=1.
//     -> sum=0, cout=8'hFF, out_valid 8 cycles after accept.
//  T6 reset mid-RUN: drop rst_n at RUN k=1.
//     -> outputs 0 immediately, in_ready=1 after release, no stray out_valid.

Source files
------------

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/sub unit: WIDTH-bit operands summed CHUNK bits per clock with a rippled carry register.
// Optional signed-overflow output enabled by defining SEQ_ADDER_OVF_EN.
module seq_chunk_adder #(
    parameter  int WIDTH  = 32,
    parameter  int CHUNK  = 4,
    localparam int NCHUNK = WIDTH / CHUNK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  sum,
    output logic [NCHUNK-1:0] cout,
    output logic              ovf
);

    localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [NCHUNK-1:0]  cout_q, cout_d;
    logic [CHUNK:0]     chunk_res;
    logic               accept;
`ifdef SEQ_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign sum       = sum_q;
    assign cout      = cout_q;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
`ifdef SEQ_ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif
        chunk_res = {1'b0, a_q[idx_q*CHUNK +: CHUNK]}
                  + {1'b0, b_q[idx_q*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_q};

        case (state_q)
            RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
                carry_d                     = chunk_res[CHUNK];
                cout_d[idx_q]               = chunk_res[CHUNK];
                if (idx_q == IDXW'(NCHUNK - 1)) begin
                    state_d = DONE;
`ifdef SEQ_ADDER_OVF_EN
                    ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &
                            (chunk_res[CHUNK-1] != a_q[WIDTH-1]);
`endif
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // A new operand set may be taken from IDLE or while retiring a result.
        if (accept) begin
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub ? 1'b1 : cin;
            idx_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef SEQ_ADDER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
